call_stack: RTL
===============

Name: call_stack

Overview:
- Parametrised LIFO return-address/data stack; successor to the fixed 8-bit, 16-entry CALL/RETURN stack in the processor control path.
- Adds configurable width and depth, full/empty/count status, and sticky overflow/underflow error flags.
- Adds a combined push+pop "replace top" operation for tail calls, and a selectable wrap-on-overflow mode.
- Sits between the sequencer (CALL/RET decode) and the PC mux; data_out feeds the return-address path.

Parameters:
WIDTH, 8, bit width of each entry
DEPTH, 16, number of entries; power of two, >= 2
OVERFLOW_WRAP, 0, 0 = push on full is dropped; 1 = push on full overwrites the oldest entry (circular)
CNT_W, $clog2(DEPTH+1), localparam, width of count

Ports:
nclk  input  1  clock; all state updates on the falling edge
reset  input  1  synchronous, active-high reset, sampled on the falling edge of nclk
push  input  1  push request (CALL)
pop  input  1  pop request (RETURN)
clr_err  input  1  clears the sticky overflow/underflow flags
data_in  input  WIDTH  value to push
data_out  output  WIDTH  current top of stack; combinational
empty  output  1  count == 0
full  output  1  count == DEPTH
count  output  CNT_W  number of valid entries
overflow  output  1  sticky; set when a push occurs while full
underflow  output  1  sticky; set when a pop occurs while empty

Behaviour:
- Reset (dominates all other inputs):
  - ptr=0, count=0, overflow=0, underflow=0; empty=1, full=0, data_out=0.
  - Storage array is not cleared.
- ptr is the next-free index and wraps modulo DEPTH; top = (ptr-1) mod DEPTH.
- data_out = mem[top] when count>0, else 0.
  - Zero-latency read: the value written by a push is visible on data_out immediately after that falling edge.
- Operations per falling edge, decoded from {push,pop}:
  - NOP (0,0): no state change.
  - PUSH (1,0), not full: mem[ptr]<=data_in; ptr<=ptr+1; count<=count+1.
  - PUSH when full, OVERFLOW_WRAP=0: no write; ptr and count unchanged; overflow<=1.
  - PUSH when full, OVERFLOW_WRAP=1: mem[ptr]<=data_in; ptr<=ptr+1; count stays DEPTH; overflow<=1 (oldest entry lost).
  - POP (0,1), not empty: ptr<=ptr-1; count<=count-1. Popped data is the data_out value before the edge.
  - POP when empty: no change; underflow<=1.
  - REPLACE (1,1), count>0: mem[top]<=data_in; ptr and count unchanged; no error even when full.
  - REPLACE (1,1), empty: no write, no change; underflow<=1.
- Sticky flags:
  - clr_err clears overflow and underflow on the next edge.
  - If an error event coincides with clr_err, the set wins.
- Pointer arithmetic: ptr is $clog2(DEPTH) bits and wraps naturally. count never exceeds DEPTH and never goes below 0.
- Debug output: each successful push emits a $display of index and value (simulation only; excluded from synthesis).

Decomposition:
- Shared package (cpu_pkg): stack_op_e enum {OP_NOP, OP_PUSH, OP_POP, OP_REPLACE} plus a helper that decodes {push,pop} into it. Default WIDTH/DEPTH constants live here, shared with the sequencer.
- One sub-module: stack_mem, a DEPTH x WIDTH register array with one synchronous write port (falling edge) and one asynchronous read port.
- Pointer, count, flags and op decode stay in call_stack.

Test Plan (WIDTH=8, DEPTH=4):
- Reset, then push 0x11,0x22,0x33 -> count=3, data_out=0x33; pop x3 -> data_out 0x22, 0x11, then 0 with empty=1.
- Push 0xA0..0xA3 -> full=1; push 0xA4 with WRAP=0 -> overflow=1, data_out=0xA3, count=4; pop x4 returns A3,A2,A1,A0.
- WRAP=1, push 0xB0..0xB4 -> overflow=1, count=4; pops return B4,B3,B2,B1, then empty=1.
- Push 0x10,0x20; assert push+pop with data_in=0x55 -> data_out=0x55, count=2; pop -> data_out=0x10.
- From empty, assert pop, then push+pop -> underflow=1, count=0; assert clr_err together with another pop -> underflow stays 1; clr_err alone -> underflow=0.
- Push 0x01,0x02; assert reset together with push of 0x03 -> count=0, empty=1, data_out=0, flags 0; next push of 0x77 -> data_out=0x77, count=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared control-path definitions: stack sizing defaults and CALL/RET op decode.
package cpu_pkg;

  localparam int unsigned STACK_WIDTH = 8;
  localparam int unsigned STACK_DEPTH = 16;

  typedef enum logic [1:0] {
    OP_NOP,
    OP_PUSH,
    OP_POP,
    OP_REPLACE
  } stack_op_e;

  function automatic stack_op_e decode_op(input logic push, input logic pop);
    case ({push, pop})
      2'b10:   return OP_PUSH;
      2'b01:   return OP_POP;
      2'b11:   return OP_REPLACE;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/stack_mem.sv
// DEPTH x WIDTH register array: falling-edge synchronous write, asynchronous read.
module stack_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             i_nclk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(negedge i_nclk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/call_stack.sv
// Parametrised LIFO return-address stack with status, sticky error flags,
// replace-top for tail calls and optional circular overwrite on overflow.
module call_stack
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH         = STACK_WIDTH,
  parameter int unsigned DEPTH         = STACK_DEPTH,
  parameter int unsigned OVERFLOW_WRAP = 0,
  localparam int unsigned CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic             nclk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clr_err,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] r_ptr, w_ptr_d, w_top, w_waddr;
  logic [CNT_W-1:0] r_count, w_count_d;
  logic             r_overflow, r_underflow;
  logic             w_ov_set, w_un_set, w_we, w_mem_we;
  logic [WIDTH-1:0] w_rdata;
  stack_op_e        w_op;

  assign w_op  = decode_op(push, pop);
  assign w_top = r_ptr - PTR_W'(1);
  assign empty = (r_count == '0);
  assign full  = (r_count == CNT_W'(DEPTH));

  always_comb begin
    w_ptr_d   = r_ptr;
    w_count_d = r_count;
    w_ov_set  = 1'b0;
    w_un_set  = 1'b0;
    w_we      = 1'b0;
    w_waddr   = r_ptr;
    unique case (w_op)
      OP_NOP: ;
      OP_PUSH: begin
        if (!full) begin
          w_we      = 1'b1;
          w_ptr_d   = r_ptr + PTR_W'(1);
          w_count_d = r_count + CNT_W'(1);
        end else begin
          w_ov_set = 1'b1;
          // Circular mode: overwrite the oldest slot, which is exactly where ptr points
          if (OVERFLOW_WRAP != 0) begin
            w_we    = 1'b1;
            w_ptr_d = r_ptr + PTR_W'(1);
          end
        end
      end
      OP_POP: begin
        if (!empty) begin
          w_ptr_d   = r_ptr - PTR_W'(1);
          w_count_d = r_count - CNT_W'(1);
        end else begin
          w_un_set = 1'b1;
        end
      end
      OP_REPLACE: begin
        if (!empty) begin
          w_we    = 1'b1;
          w_waddr = w_top;
        end else begin
          w_un_set = 1'b1;
        end
      end
    endcase
  end

  always_ff @(negedge nclk) begin
    if (reset) begin
      r_ptr       <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_ptr       <= w_ptr_d;
      r_count     <= w_count_d;
      r_overflow  <= (r_overflow & ~clr_err) | w_ov_set;
      r_underflow <= (r_underflow & ~clr_err) | w_un_set;
    end
  end

  // Reset also blocks the array write; the array itself is never cleared
  assign w_mem_we = w_we & ~reset;

  stack_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_mem (
    .i_nclk (nclk),
    .i_we   (w_mem_we),
    .i_waddr(w_waddr),
    .i_wdata(data_in),
    .i_raddr(w_top),
    .o_rdata(w_rdata)
  );

  assign data_out  = empty ? '0 : w_rdata;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

`ifndef SYNTHESIS
  always @(negedge nclk) begin
    if (w_mem_we && w_op == OP_PUSH) begin
      $display("call_stack: push idx=%0d data=0x%h", w_waddr, data_in);
    end
  end
`endif

endmodule
